// File: rtl/link_mm_master.sv
// Single-outstanding bridge from a valid/ready host request channel to a
// strobe-based MM address decoder, with a read timeout that returns a tagged error word.
module link_mm_master #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 64,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              oMM_WR_EN,
    output logic              oMM_RD_EN,
    output logic [ADDR_W-1:0] oMM_ADDR,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    input  logic              iMM_RD_DATA_V,
    output logic [15:0]       timeout_cnt
);

    localparam int          TMR_W  = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [63:0] TO_PAT = 64'hDEAD_BEEF_0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                rsp_wr_q, rsp_wr_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [15:0]         to_cnt_q, to_cnt_d;

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        timer_d     = timer_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        to_cnt_d    = to_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    rsp_wr_d    = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    timer_d = '0;
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                timer_d = timer_q + TMR_W'(1);
                // Data arriving on the timeout cycle still counts as a good read.
                if (iMM_RD_DATA_V) begin
                    rsp_rdata_d = iMM_RD_DATA;
                    rsp_err_d   = 1'b0;
                    rsp_wr_d    = 1'b0;
                    state_d     = S_RESP;
                end else if (timer_q == TMR_W'(RD_TIMEOUT)) begin
                    rsp_rdata_d = DATA_W'(TO_PAT) | DATA_W'(addr_q);
                    rsp_err_d   = 1'b1;
                    rsp_wr_d    = 1'b0;
                    if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            timer_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            to_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            timer_q     <= timer_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            to_cnt_q    <= to_cnt_d;
        end
    end

    // Strobes are decoded from state so they can only ever be one-cycle and exclusive.
    assign req_ready   = (state_q == S_IDLE);
    assign oMM_WR_EN   = (state_q == S_ISSUE) && wr_q;
    assign oMM_RD_EN   = (state_q == S_ISSUE) && !wr_q;
    assign oMM_ADDR    = addr_q;
    assign oMM_WR_DATA = wdata_q;
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_wr      = rsp_wr_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_link_mm_master.sv
// Directed bench for link_mm_master: a transaction-level model predicts strobes,
// response contents and strobe-to-response latency; a negedge monitor checks every cycle.
module tb_link_mm_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [16:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [63:0] rsp_rdata;
    logic        oMM_WR_EN, oMM_RD_EN;
    logic [16:0] oMM_ADDR;
    logic [63:0] oMM_WR_DATA, iMM_RD_DATA;
    logic        iMM_RD_DATA_V;
    logic [15:0] timeout_cnt;

    link_mm_master #(.ADDR_W(17), .DATA_W(64), .RD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .oMM_WR_EN(oMM_WR_EN), .oMM_RD_EN(oMM_RD_EN), .oMM_ADDR(oMM_ADDR),
        .oMM_WR_DATA(oMM_WR_DATA), .iMM_RD_DATA(iMM_RD_DATA),
        .iMM_RD_DATA_V(iMM_RD_DATA_V), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [16:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;   // cycles from strobe to first rsp_valid
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          total = 0;
    int          bad   = 0;
    int          exp_to = 0;
    int          cyc = 0, acc_cyc = 0, stb_cyc = 0;
    bit          busy = 0, rsp_seen = 0;
    int          dec_dly = -1;
    logic [63:0] dec_data = '0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 0, last_wr = 0;
    int          last_lat = 0;
    logic [16:0] last_stb_addr = '0;
    logic [63:0] last_stb_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decoder stand-in: answers a read strobe dec_dly cycles later with a one-cycle pulse.
    initial begin
        iMM_RD_DATA_V = 1'b0;
        iMM_RD_DATA   = '0;
        forever begin
            @(negedge clk);
            if (oMM_RD_EN && dec_dly >= 1) begin
                int d;
                d = dec_dly;
                repeat (d) @(posedge clk);
                #1 iMM_RD_DATA_V = 1'b1; iMM_RD_DATA = dec_data;
                @(posedge clk);
                #1 iMM_RD_DATA_V = 1'b0; iMM_RD_DATA = '0;
            end
        end
    end

    // Monitor: compares DUT outputs with the head of the expectation queue each cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                busy = 0; rsp_seen = 0; exp_to = 0;
                continue;
            end
            chk("strobe_excl", 64'(oMM_WR_EN && oMM_RD_EN), 64'd0);
            chk("req_ready", 64'(req_ready), 64'(!busy));
            if (!busy) begin
                chk("idle_quiet", 64'({oMM_WR_EN, oMM_RD_EN, rsp_valid}), 64'd0);
                if (req_valid && req_ready) begin
                    busy = 1; acc_cyc = cyc;
                end
            end else begin
                chk("queue_depth", 64'(exp_q.size()), 64'd1);
                cur = exp_q[0];
                if (oMM_WR_EN || oMM_RD_EN) begin
                    chk("stb_cycle", 64'(cyc - acc_cyc), 64'd1);
                    chk("stb_wr", 64'(oMM_WR_EN), 64'(cur.wr));
                    chk("stb_rd", 64'(oMM_RD_EN), 64'(!cur.wr));
                    chk("stb_addr", 64'(oMM_ADDR), 64'(cur.addr));
                    chk("stb_data", oMM_WR_DATA, cur.wdata);
                    stb_cyc = cyc;
                    last_stb_addr = oMM_ADDR;
                    last_stb_data = oMM_WR_DATA;
                end
                if (rsp_valid) begin
                    if (!rsp_seen) begin
                        chk("rsp_latency", 64'(cyc - stb_cyc), 64'(cur.lat));
                        last_lat = cyc - stb_cyc;
                    end
                    rsp_seen = 1;
                    chk("rsp_wr", 64'(rsp_wr), 64'(cur.wr));
                    chk("rsp_err", 64'(rsp_err), 64'(cur.err));
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    if (rsp_ready) begin
                        chk("timeout_cnt", 64'(timeout_cnt), 64'(exp_to));
                        last_rdata = rsp_rdata; last_err = rsp_err; last_wr = rsp_wr;
                        void'(exp_q.pop_front());
                        busy = 0; rsp_seen = 0;
                    end
                end
            end
        end
    end

    // One host transaction; dly is the decoder answer delay in cycles after the strobe
    // (outside 1..TO+1 the read must time out), hold is how many response cycles are backpressured.
    task automatic do_req(input logic wr, input logic [16:0] addr, input logic [63:0] wdata,
                          input int dly, input logic [63:0] ddata, input int hold);
        txn_t t;
        int   n;
        t.wr = wr; t.addr = addr; t.wdata = wdata;
        if (wr) begin
            t.rdata = '0; t.err = 0; t.lat = 1;
        end else if (dly >= 1 && dly <= TO + 1) begin
            t.rdata = ddata; t.err = 0; t.lat = dly + 1;
        end else begin
            t.rdata = 64'hDEAD_BEEF_0000_0000 | {47'd0, addr}; t.err = 1; t.lat = TO + 2;
            exp_to++;
        end
        exp_q.push_back(t);
        dec_dly = dly; dec_data = ddata;
        req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1 req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrives", 64'(rsp_valid), 64'd1);
        if (!rsp_valid) begin
            rsp_ready = 0;
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 rsp_ready = 1;
        end
        @(posedge clk);
        #1 rsp_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        txn_t t;
        rst = 1; req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_outs", 64'({rsp_valid, rsp_wr, rsp_err, oMM_WR_EN, oMM_RD_EN}), 64'd0);
        chk("reset_rdata", rsp_rdata, 64'd0);
        chk("reset_tocnt", 64'(timeout_cnt), 64'd0);
        @(posedge clk); #1;

        // write
        do_req(1, 17'h04010, 64'h1234, -1, '0, 0);
        chk("wr_lit_addr", 64'(last_stb_addr), 64'h04010);
        chk("wr_lit_data", last_stb_data, 64'h1234);
        chk("wr_lit_rsp", 64'({last_wr, last_err}), 64'b10);
        chk("wr_lit_lat", 64'(last_lat), 64'd1);

        // read, decoder answers 3 cycles after strobe
        do_req(0, 17'h08008, 64'h0, 3, 64'hCAFE, 0);
        chk("rd_lit_rdata", last_rdata, 64'hCAFE);
        chk("rd_lit_err", 64'(last_err), 64'd0);
        chk("rd_lit_lat", 64'(last_lat), 64'd4);

        // timeout
        do_req(0, 17'h08008, 64'h0, -1, '0, 0);
        chk("to_lit_rdata", last_rdata, 64'hDEAD_BEEF_0000_8008);
        chk("to_lit_err", 64'(last_err), 64'd1);
        chk("to_lit_cnt", 64'(timeout_cnt), 64'd1);

        // data on the timeout cycle wins
        do_req(0, 17'h00123, 64'h0, TO + 1, 64'h5A5A, 0);
        chk("race_lit_rdata", last_rdata, 64'h5A5A);
        chk("race_lit_cnt", 64'(timeout_cnt), 64'd1);

        // data one cycle too late: timeout, stray pulse lands in RESP and is dropped
        do_req(0, 17'h1FFFF, 64'h0, TO + 2, 64'h7777, 0);
        chk("late_lit_rdata", last_rdata, 64'hDEAD_BEEF_0001_FFFF);
        chk("late_lit_cnt", 64'(timeout_cnt), 64'd2);

        // backpressure for 10 cycles, then a back-to-back write
        do_req(0, 17'h00ABC, 64'h0, 2, 64'hA5A5_0000_FFFF_0001, 10);
        chk("bp_lit_rdata", last_rdata, 64'hA5A5_0000_FFFF_0001);
        do_req(1, 17'h10001, 64'hFFFF_0000_1111_2222, -1, '0, 3);
        chk("bp_lit_wr", 64'({last_wr, last_err}), 64'b10);

        // reset while waiting on a read, then data arrives after release
        t.wr = 0; t.addr = 17'h0F0F0; t.wdata = 64'h0; t.rdata = '0; t.err = 0; t.lat = 0;
        exp_q.push_back(t);
        dec_dly = -1;
        req_valid = 1; req_wr = 0; req_addr = 17'h0F0F0; req_wdata = '0;
        @(posedge clk);
        #1 req_valid = 0; req_addr = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1 iMM_RD_DATA_V = 1; iMM_RD_DATA = 64'hCAFE;
        @(posedge clk);
        #1 iMM_RD_DATA_V = 0; iMM_RD_DATA = '0;
        repeat (2) @(negedge clk);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_outs", 64'({rsp_valid, rsp_wr, rsp_err, oMM_WR_EN, oMM_RD_EN}), 64'd0);
        chk("rst_mid_rdata", rsp_rdata, 64'd0);
        chk("rst_mid_addr", 64'(oMM_ADDR), 64'd0);
        chk("rst_mid_wdata", oMM_WR_DATA, 64'd0);
        chk("rst_mid_tocnt", 64'(timeout_cnt), 64'd0);
        @(posedge clk); #1;

        // block still works after the mid-transaction reset
        do_req(0, 17'h00042, 64'h0, 1, 64'h0BAD_F00D, 0);
        chk("post_rst_rdata", last_rdata, 64'h0BAD_F00D);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_mm_master.md
LINK_MM_MASTER -- requirements
Module: link_mm_master

Interface
REQ-001 Parameter ADDR_W, default 17, sets the MM address width.
REQ-002 Parameter DATA_W, default 64, sets the MM data width.
REQ-003 Parameter RD_TIMEOUT, default 255, is the maximum number of WAIT_RD cycles before a read is abandoned.
REQ-004 Design uses one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port req_valid, input, 1 bit: host request present.
REQ-008 Port req_ready, output, 1 bit: block accepts a request this cycle.
REQ-009 Port req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-010 Port req_addr, input, ADDR_W bits: target address.
REQ-011 Port req_wdata, input, DATA_W bits: write data.
REQ-012 Port rsp_valid, output, 1 bit: response present.
REQ-013 Port rsp_ready, input, 1 bit: host accepts the response.
REQ-014 Port rsp_wr, output, 1 bit: response is a write acknowledge.
REQ-015 Port rsp_err, output, 1 bit: read timed out.
REQ-016 Port rsp_rdata, output, DATA_W bits: read data.
REQ-017 Port oMM_WR_EN, output, 1 bit: write strobe to the address decoder.
REQ-018 Port oMM_RD_EN, output, 1 bit: read strobe to the address decoder.
REQ-019 Port oMM_ADDR, output, ADDR_W bits: MM address.
REQ-020 Port oMM_WR_DATA, output, DATA_W bits: MM write data.
REQ-021 Port iMM_RD_DATA, input, DATA_W bits: read data returned by the decoder.
REQ-022 Port iMM_RD_DATA_V, input, 1 bit: read data valid, single-cycle pulse.
REQ-023 Port timeout_cnt, output, 16 bits: saturating count of read timeouts.

Function
REQ-024 FSM states are IDLE, ISSUE, WAIT_RD and RESP; req_ready SHALL be 1 only in IDLE.
REQ-025 IDLE with req_valid=1: capture req_wr, req_addr and req_wdata, then go to ISSUE next cycle.
REQ-026 ISSUE lasts exactly 1 cycle: oMM_ADDR and oMM_WR_DATA = captured values; oMM_WR_EN = req_wr or oMM_RD_EN = !req_wr, pulsed for that cycle only.
REQ-027 From ISSUE, a write goes to RESP with rsp_wr=1, rsp_err=0 and rsp_rdata=0.
REQ-028 From ISSUE, a read goes to WAIT_RD with a timer cleared to 0.
REQ-029 WAIT_RD: timer increments each cycle.
REQ-030 WAIT_RD with iMM_RD_DATA_V=1: register iMM_RD_DATA into rsp_rdata, set rsp_err=0 and rsp_wr=0, go to RESP.
REQ-031 WAIT_RD with timer==RD_TIMEOUT and no valid: rsp_rdata = 64'hDEAD_BEEF_0000_0000 OR zero-extended address, rsp_err=1, timeout_cnt increments (saturating at 16'hFFFF), go to RESP.
REQ-032 When iMM_RD_DATA_V=1 in the same cycle as timeout, the valid data wins and no error is flagged.
REQ-033 RESP: rsp_valid=1 with rsp_* held stable until rsp_ready=1, then go to IDLE; no new request is accepted in that cycle.
REQ-034 iMM_RD_DATA_V outside WAIT_RD is ignored (late or stray data is dropped).
REQ-035 At most 1 transaction is outstanding at any time; oMM_WR_EN and oMM_RD_EN are never both 1.
REQ-036 Minimum write turnaround is accept, ISSUE, RESP (3 cycles with rsp_ready held at 1); read latency = 2 + decoder latency.

Reset
REQ-037 rst=1 at any state, including mid-transaction, forces IDLE on the next edge.
REQ-038 Reset clears oMM_WR_EN, oMM_RD_EN, oMM_ADDR, oMM_WR_DATA, rsp_valid, rsp_wr, rsp_err, rsp_rdata, timeout_cnt and the timer to 0; req_ready becomes 1 after reset is released.
REQ-039 Any read data arriving after reset is ignored per REQ-034.

Verification
REQ-040 Write test: req wr=1, addr=17'h04010, wdata=64'h1234 -> one-cycle oMM_WR_EN with the same addr/data, then rsp_valid with rsp_wr=1 and rsp_err=0.
REQ-041 Read test: addr=17'h08008 with decoder returning 64'hCAFE 3 cycles after the strobe -> rsp_rdata=64'hCAFE, rsp_err=0.
REQ-042 Timeout test: read with no data valid -> at RD_TIMEOUT, rsp_err=1, rsp_rdata=64'hDEAD_BEEF_0000_0000 | addr, and timeout_cnt increments by 1.
REQ-043 Backpressure test: rsp_ready held at 0 for 10 cycles -> rsp_* stable and req_ready=0 throughout.
REQ-044 Reset test: rst asserted during WAIT_RD, then data valid arrives after release -> FSM in IDLE, no rsp_valid, all outputs 0.
REQ-045 Race test: data valid on the timeout cycle -> data returned with rsp_err=0 and timeout_cnt unchanged.
